imm_packer: RTL and testbench

//   Inverse of the immediate extender. Takes a 32-bit constant plus a destination register and

---
 rtl/imm_packer.sv | 162 ++++++++++++++++
 tb/tb_imm_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// Turns a 32-bit constant into the shortest addiu / ori / lui / lui+ori sequence that loads it.
// Optional pair counter: define IMM_PACK_STATS_EN.
`timescale 1ns/1ps
module imm_packer #(
    parameter logic [5:0] OP_ADDIU = 6'h09,
    parameter logic [5:0] OP_ORI   = 6'h0D,
    parameter logic [5:0] OP_LUI   = 6'h0F,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_value,
    input  logic [4:0]       in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_eop,
    output logic             out_last,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [1:0]  out_eop_q, out_eop_d;
    logic        out_last_q, out_last_d;
    logic [15:0] lo_q, lo_d;
    logic [4:0]  rt_q, rt_d;
    logic        two_q, two_d;

    logic fits_addiu, fits_ori, fits_lui;

    // Classification is done on the incoming value at capture; the second word only needs lo/rt.
    assign fits_addiu = (&in_value[31:15]) | ~(|in_value[31:15]);
    assign fits_ori   = (in_value[31:16] == 16'h0000);
    assign fits_lui   = (in_value[15:0] == 16'h0000);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_eop_d   = out_eop_q;
        out_last_d  = out_last_q;
        lo_d        = lo_q;
        rt_d        = rt_q;
        two_d       = two_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d     = EMIT1;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    lo_d        = in_value[15:0];
                    rt_d        = in_rt;
                    if (fits_addiu) begin
                        out_instr_d = {OP_ADDIU, 5'd0, in_rt, in_value[15:0]};
                        out_eop_d   = 2'b00;
                        out_last_d  = 1'b1;
                        two_d       = 1'b0;
                    end else if (fits_ori) begin
                        out_instr_d = {OP_ORI, 5'd0, in_rt, in_value[15:0]};
                        out_eop_d   = 2'b01;
                        out_last_d  = 1'b1;
                        two_d       = 1'b0;
                    end else begin
                        out_instr_d = {OP_LUI, 5'd0, in_rt, in_value[31:16]};
                        out_eop_d   = 2'b10;
                        out_last_d  = fits_lui;
                        two_d       = ~fits_lui;
                    end
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    if (two_q) begin
                        state_d     = EMIT2;
                        out_instr_d = {OP_ORI, rt_q, rt_q, lo_q};
                        out_eop_d   = 2'b01;
                        out_last_d  = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_eop_q   <= 2'b00;
            out_last_q  <= 1'b0;
            lo_q        <= 16'h0;
            rt_q        <= 5'd0;
            two_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_eop_q   <= out_eop_d;
            out_last_q  <= out_last_d;
            lo_q        <= lo_d;
            rt_q        <= rt_d;
            two_q       <= two_d;
        end
    end

`ifdef IMM_PACK_STATS_EN
    logic [CNT_W-1:0] pair_q, pair_d;

    // Counts the lui->ori transition and sticks at all-ones.
    always_comb begin
        pair_d = pair_q;
        if (state_q == EMIT1 && out_ready && two_q && !(&pair_q))
            pair_d = pair_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pair_q <= '0;
        else
            pair_q <= pair_d;
    end

    assign pair_cnt = pair_q;
`else
    assign pair_cnt = '0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_imm   = out_instr_q[15:0];
    assign out_eop   = out_eop_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_imm_packer.sv
// Directed and round-trip bench for imm_packer.
`timescale 1ns/1ps
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_value = 32'h0;
    logic [4:0]  in_rt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic [15:0] pair_cnt;

    int checks = 0;
    int errors = 0;
    int exp_pairs = 0;

    imm_packer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm(out_imm), .out_eop(out_eop), .out_last(out_last), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_cnt();
`ifdef IMM_PACK_STATS_EN
        return exp_pairs[15:0];
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
        case (eop)
            2'b00:   return {{16{imm[15]}}, imm};
            2'b01:   return {16'h0, imm};
            2'b10:   return {imm, 16'h0};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic [4:0] rt);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        in_value = v;
        in_rt    = rt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_word(output logic [31:0] instr, output logic [1:0] eop,
                            output logic last, output logic [15:0] imm);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL get_word_timeout out_valid=%b required 1", out_valid);
        end
        instr = out_instr;
        eop   = out_eop;
        last  = out_last;
        imm   = out_imm;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0)    begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (out_imm !== 16'h0)      begin errors++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
        checks++; if (out_eop !== 2'b00)      begin errors++; $display("FAIL reset_out_eop got=%b exp=00", out_eop); end
        checks++; if (out_last !== 1'b0)      begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (pair_cnt !== 16'h0)     begin errors++; $display("FAIL reset_pair_cnt got=%0d exp=0", pair_cnt); end
        reset = 1'b1;
        tick();
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_addiu();
        out_ready = 1'b1;
        send(32'h0000_1234, 5'd8);
        checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL addiu_valid got=%b exp=1", out_valid); end
        checks++; if (in_ready !== 1'b0)         begin errors++; $display("FAIL addiu_busy got=%b exp=0", in_ready); end
        checks++; if (out_instr !== 32'h2408_1234) begin errors++; $display("FAIL addiu_instr got=%h exp=24081234", out_instr); end
        checks++; if (out_eop !== 2'b00)         begin errors++; $display("FAIL addiu_eop got=%b exp=00", out_eop); end
        checks++; if (out_last !== 1'b1)         begin errors++; $display("FAIL addiu_last got=%b exp=1", out_last); end
        checks++; if (out_imm !== 16'h1234)      begin errors++; $display("FAIL addiu_imm got=%h exp=1234", out_imm); end
        $display("addiu: v=00001234 rt=8 instr=%h eop=%b last=%b", out_instr, out_eop, out_last);
        tick();
        checks++; if (out_valid !== 1'b0)        begin errors++; $display("FAIL addiu_done_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)         begin errors++; $display("FAIL addiu_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_classes();
        logic [31:0] vals  [8] = '{32'hFFFF_8000, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_7FFF,
                                   32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0000};
        logic [4:0]  rts   [8] = '{5'd9, 5'd9, 5'd0, 5'd31, 5'd2, 5'd3, 5'd4, 5'd5};
        logic [31:0] instrs[8] = '{32'h2409_8000, 32'h3409_ABCD, 32'h2400_0000, 32'h241F_7FFF,
                                   32'h3402_8000, 32'h2403_FFFF, 32'h3404_FFFF, 32'h3C05_0001};
        logic [1:0]  eops  [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
        logic [31:0] instr;
        logic [1:0]  eop;
        logic        last;
        logic [15:0] imm;
        for (int i = 0; i < 8; i++) begin
            send(vals[i], rts[i]);
            get_word(instr, eop, last, imm);
            $display("class: v=%h rt=%0d instr=%h eop=%b last=%b", vals[i], rts[i], instr, eop, last);
            checks++; if (instr !== instrs[i])          begin errors++; $display("FAIL class_instr v=%h got=%h exp=%h", vals[i], instr, instrs[i]); end
            checks++; if (eop !== eops[i])              begin errors++; $display("FAIL class_eop v=%h got=%b exp=%b", vals[i], eop, eops[i]); end
            checks++; if (last !== 1'b1)                begin errors++; $display("FAIL class_last v=%h got=%b exp=1", vals[i], last); end
            checks++; if (imm !== instrs[i][15:0])      begin errors++; $display("FAIL class_imm v=%h got=%h exp=%h", vals[i], imm, instrs[i][15:0]); end
            checks++; if (out_valid !== 1'b0)           begin errors++; $display("FAIL class_single v=%h out_valid=%b exp=0", vals[i], out_valid); end
        end
    endtask

    task automatic test_lui();
        logic [31:0] instr;
        logic [1:0]  eop;
        logic        last;
        logic [15:0] imm;
        send(32'hABCD_0000, 5'd1);
        get_word(instr, eop, last, imm);
        $display("lui: v=ABCD0000 rt=1 instr=%h eop=%b last=%b", instr, eop, last);
        checks++; if (instr !== 32'h3C01_ABCD) begin errors++; $display("FAIL lui_instr got=%h exp=3c01abcd", instr); end
        checks++; if (eop !== 2'b10)           begin errors++; $display("FAIL lui_eop got=%b exp=10", eop); end
        checks++; if (last !== 1'b1)           begin errors++; $display("FAIL lui_last got=%b exp=1", last); end
        checks++; if (out_valid !== 1'b0)      begin errors++; $display("FAIL lui_single got=%b exp=0", out_valid); end
        checks++; if (pair_cnt !== exp_cnt())  begin errors++; $display("FAIL lui_pair_cnt got=%0d exp=%0d", pair_cnt, exp_cnt()); end
    endtask

    task automatic test_pair_stall();
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd10);
        // Competing request held during the stall must not be captured.
        in_value = 32'h0000_0001;
        in_rt    = 5'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1)          begin errors++; $display("FAIL pair_w1_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_instr !== 32'h3C0A_1234) begin errors++; $display("FAIL pair_w1_instr cyc=%0d got=%h exp=3c0a1234", i, out_instr); end
            checks++; if (out_eop !== 2'b10)           begin errors++; $display("FAIL pair_w1_eop cyc=%0d got=%b exp=10", i, out_eop); end
            checks++; if (out_last !== 1'b0)           begin errors++; $display("FAIL pair_w1_last cyc=%0d got=%b exp=0", i, out_last); end
            checks++; if (in_ready !== 1'b0)           begin errors++; $display("FAIL pair_w1_busy cyc=%0d got=%b exp=0", i, in_ready); end
            if (i < 3) tick();
        end
        $display("pair: word1 instr=%h eop=%b last=%b", out_instr, out_eop, out_last);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1)          begin errors++; $display("FAIL pair_w2_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_instr !== 32'h354A_5678) begin errors++; $display("FAIL pair_w2_instr cyc=%0d got=%h exp=354a5678", i, out_instr); end
            checks++; if (out_eop !== 2'b01)           begin errors++; $display("FAIL pair_w2_eop cyc=%0d got=%b exp=01", i, out_eop); end
            checks++; if (out_last !== 1'b1)           begin errors++; $display("FAIL pair_w2_last cyc=%0d got=%b exp=1", i, out_last); end
            checks++; if (in_ready !== 1'b0)           begin errors++; $display("FAIL pair_w2_busy cyc=%0d got=%b exp=0", i, in_ready); end
            if (i < 3) tick();
        end
        $display("pair: word2 instr=%h eop=%b last=%b", out_instr, out_eop, out_last);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_pairs++;
        checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL pair_done_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)      begin errors++; $display("FAIL pair_done_ready got=%b exp=1", in_ready); end
        checks++; if (pair_cnt !== exp_cnt()) begin errors++; $display("FAIL pair_cnt got=%0d exp=%0d", pair_cnt, exp_cnt()); end
        tick();
        checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL pair_no_capture got=%b exp=0", out_valid); end
    endtask

    task automatic test_round_trip();
        logic [31:0] v, acc, rsval;
        logic [4:0]  rt;
        logic [31:0] instr;
        logic [1:0]  eop;
        logic        last;
        logic [15:0] imm;
        int          words;
        bit          two;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            case ($urandom_range(0, 3))
                0: v = v & 32'hFFFF_0000;
                1: v = v & 32'h0000_FFFF;
                2: v = {{16{v[15]}}, v[15:0]};
                default: ;
            endcase
            rt = 5'($urandom_range(1, 31));
            two = !((&v[31:15]) || !(|v[31:15])) && (v[31:16] != 16'h0) && (v[15:0] != 16'h0);
            send(v, rt);
            acc   = 32'h0;
            words = 0;
            last  = 1'b0;
            while (!last && words < 3) begin
                get_word(instr, eop, last, imm);
                words++;
                checks++; if (instr[20:16] !== rt || imm !== instr[15:0] || eop === 2'b11) begin
                    errors++; $display("FAIL rt_fields v=%h instr=%h imm=%h eop=%b rt=%0d", v, instr, imm, eop, rt);
                end
                rsval = (instr[25:21] == 5'd0) ? 32'h0 : acc;
                case (instr[31:26])
                    6'h09:   acc = rsval + ext(imm, eop);
                    6'h0D:   acc = rsval | ext(imm, eop);
                    6'h0F:   acc = ext(imm, eop);
                    default: acc = 32'hBAD0_BAD0;
                endcase
            end
            $display("roundtrip: v=%h rt=%0d words=%0d result=%h", v, rt, words, acc);
            checks++; if (acc !== v)                  begin errors++; $display("FAIL rt_value got=%h exp=%h", acc, v); end
            checks++; if (words != (two ? 2 : 1))     begin errors++; $display("FAIL rt_words v=%h got=%0d exp=%0d", v, words, two ? 2 : 1); end
            if (two) exp_pairs++;
        end
        checks++; if (pair_cnt !== exp_cnt()) begin errors++; $display("FAIL rt_pair_cnt got=%0d exp=%0d", pair_cnt, exp_cnt()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin
            errors++; $display("FAIL mid_in_emit2 valid=%b last=%b exp=1/1", out_valid, out_last);
        end
        #2;
        reset = 1'b0;
        #1;
        exp_pairs = 0;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
        checks++; if (pair_cnt !== 16'h0)   begin errors++; $display("FAIL mid_pair_cnt got=%0d exp=0", pair_cnt); end
        checks++; if (out_instr !== 32'h0)  begin errors++; $display("FAIL mid_instr got=%h exp=0", out_instr); end
        checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL mid_last got=%b exp=0", out_last); end
        $display("reset_mid: out_valid=%b in_ready=%b pair_cnt=%0d", out_valid, in_ready, pair_cnt);
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_word2 cyc=%0d got=%b exp=0", i, out_valid); end
            checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_idle_ready cyc=%0d got=%b exp=1", i, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_classes();
        test_lui();
        test_pair_stall();
        test_round_trip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
